// File: rtl/ysyx_22051013_mdu_ctrl.sv
// RV64M multiply/divide sequencer: one bit per cycle shift-add multiplier and restoring
// divider, single outstanding op, result held until writeback accepts it.
module ysyx_22051013_mdu_ctrl #(
    parameter int XLEN          = 64,
    parameter bit EARLY_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t       state_r;
    logic [3:0]   op_r;
    logic [63:0]  src1_r, src2_r, opnd_r, spec_res_r, result_r;
    logic [128:0] acc_r;
    logic [6:0]   cnt_r;
    logic         neg_r, special_r, in_ready_r, busy_r, out_valid_r;

    logic         word_s, is_div_s, signed1_s, signed2_s, sign_a_s, sign_b_s;
    logic         div_zero_s, ovf_s, illegal_s, special_s, neg_s, ge_s;
    logic [63:0]  a_ext_s, b_ext_s, abs_a_s, abs_b_s, min_s, spec_val_s, sel_s, fix_val_s;
    logic [64:0]  add_s, shl_s;
    logic [128:0] mul_next_s, div_next_s;
    logic [127:0] prod_s, prod_fix_s;

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // Operand conditioning and special-case detection, evaluated while in PREP
    always_comb begin
        word_s    = op_r[3];
        is_div_s  = op_r[2];
        signed1_s = 1'b0;
        signed2_s = 1'b0;
        case (op_r[2:0])
            3'b001, 3'b100, 3'b110: begin signed1_s = 1'b1; signed2_s = 1'b1; end
            3'b010:                 begin signed1_s = 1'b1; signed2_s = 1'b0; end
            default:                begin signed1_s = 1'b0; signed2_s = 1'b0; end
        endcase
        if (word_s) begin
            a_ext_s = signed1_s ? sext32(src1_r[31:0]) : {32'd0, src1_r[31:0]};
            b_ext_s = signed2_s ? sext32(src2_r[31:0]) : {32'd0, src2_r[31:0]};
            min_s   = 64'hFFFF_FFFF_8000_0000;
        end else begin
            a_ext_s = src1_r;
            b_ext_s = src2_r;
            min_s   = 64'h8000_0000_0000_0000;
        end
        sign_a_s   = signed1_s & a_ext_s[63];
        sign_b_s   = signed2_s & b_ext_s[63];
        abs_a_s    = sign_a_s ? (64'd0 - a_ext_s) : a_ext_s;
        abs_b_s    = sign_b_s ? (64'd0 - b_ext_s) : b_ext_s;
        div_zero_s = (b_ext_s == 64'd0);
        ovf_s      = signed2_s & (a_ext_s == min_s) & (b_ext_s == 64'hFFFF_FFFF_FFFF_FFFF);
        illegal_s  = word_s & ~op_r[2] & (op_r[1:0] != 2'b00);
        special_s  = illegal_s | (is_div_s & (div_zero_s | ovf_s));
        // Remainder follows the dividend sign; quotient and product follow the sign XOR
        neg_s      = (is_div_s & op_r[1]) ? sign_a_s : (sign_a_s ^ sign_b_s);
        if (illegal_s) begin
            spec_val_s = 64'd0;
        end else if (div_zero_s) begin
            spec_val_s = op_r[1] ? (word_s ? sext32(src1_r[31:0]) : src1_r)
                                 : 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            spec_val_s = op_r[1] ? 64'd0 : a_ext_s;
        end
    end

    // One iteration of each algorithm; acc holds {remainder, quotient} or {product_hi, multiplier}
    always_comb begin
        add_s      = {1'b0, acc_r[127:64]} + {1'b0, opnd_r};
        mul_next_s = acc_r[0] ? ({add_s, acc_r[63:0]} >> 1) : (acc_r >> 1);
        shl_s      = {acc_r[127:64], acc_r[63]};
        ge_s       = (shl_s >= {1'b0, opnd_r});
        if (ge_s) begin
            div_next_s = {shl_s - {1'b0, opnd_r}, acc_r[62:0], 1'b1};
        end else begin
            div_next_s = {shl_s, acc_r[62:0], 1'b0};
        end
    end

    // Sign fix-up and result selection; a word product ends up 32 bits above its final place
    always_comb begin
        prod_s     = word_s ? {32'd0, acc_r[127:32]} : acc_r[127:0];
        prod_fix_s = neg_r ? (128'd0 - prod_s) : prod_s;
        case (op_r[2:0])
            3'b000:                 sel_s = prod_fix_s[63:0];
            3'b001, 3'b010, 3'b011: sel_s = prod_fix_s[127:64];
            3'b100, 3'b101:         sel_s = neg_r ? (64'd0 - acc_r[63:0]) : acc_r[63:0];
            3'b110, 3'b111:         sel_s = neg_r ? (64'd0 - acc_r[127:64]) : acc_r[127:64];
            default:                sel_s = 64'd0;
        endcase
        if (special_r) begin
            fix_val_s = spec_res_r;
        end else begin
            fix_val_s = word_s ? sext32(sel_s[31:0]) : sel_s;
        end
    end

    // Control FSM with registered handshake outputs; flush acts as the synchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            op_r        <= 4'd0;
            src1_r      <= 64'd0;
            src2_r      <= 64'd0;
            opnd_r      <= 64'd0;
            acc_r       <= 129'd0;
            cnt_r       <= 7'd0;
            neg_r       <= 1'b0;
            special_r   <= 1'b0;
            spec_res_r  <= 64'd0;
            result_r    <= 64'd0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r       <= op;
                        src1_r     <= src1;
                        src2_r     <= src2;
                        state_r    <= S_PREP;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
                S_PREP: begin
                    opnd_r     <= abs_b_s;
                    acc_r      <= {65'd0, (is_div_s & word_s) ? {abs_a_s[31:0], 32'd0} : abs_a_s};
                    cnt_r      <= word_s ? 7'd32 : 7'd64;
                    neg_r      <= neg_s;
                    special_r  <= special_s;
                    spec_res_r <= spec_val_s;
                    state_r    <= (special_s && EARLY_SPECIAL) ? S_FIX : S_CALC;
                end
                S_CALC: begin
                    acc_r   <= is_div_s ? div_next_s : mul_next_s;
                    cnt_r   <= cnt_r - 7'd1;
                    state_r <= (cnt_r == 7'd1) ? S_FIX : S_CALC;
                end
                S_FIX: begin
                    result_r    <= fix_val_s;
                    out_valid_r <= 1'b1;
                    state_r     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= S_IDLE;
                    end else begin
                        state_r     <= S_DONE;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;

endmodule

// File: tb/tb_ysyx_22051013_mdu_ctrl.sv
// Directed bench for the multiply/divide sequencer: results, latency, specials, flush,
// backpressure and asynchronous reset.
module tb_ysyx_22051013_mdu_ctrl;

    logic        clk, rst, in_valid, in_ready, flush, busy, out_valid, out_ready;
    logic [3:0]  op;
    logic [63:0] src1, src2, result;
    int          n_cmp = 0;
    int          n_err = 0;
    int          seen;
    int          edges;

    ysyx_22051013_mdu_ctrl #(.XLEN(64), .EARLY_SPECIAL(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .src1(src1), .src2(src2), .flush(flush), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Latency is reported as a cycle index with the accept cycle as cycle 0
    task automatic do_op(input string tag, input logic [3:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat);
        int e;
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = o; src1 = a; src2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = 0;
        while (out_valid !== 1'b1 && e < 200) begin
            @(posedge clk); #1;
            e++;
        end
        check({tag, "_lat"}, 64'(e + 1), 64'(exp_lat));
        check({tag, "_res"}, result, exp_res);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ret"}, {61'd0, out_valid, in_ready, busy}, 64'd2);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = 4'd0; src1 = 64'd0; src2 = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", result, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        do_op("mul", 4'h0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 67);
        do_op("mulhu", 4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 67);
        do_op("mulhsu", 4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67);
        do_op("mulh", 4'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 67);
        do_op("div", 4'h4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67);
        do_op("rem", 4'h6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67);
        do_op("divu0", 4'h5, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        do_op("rem0", 4'h6, 64'd100, 64'd0, 64'd100, 3);
        do_op("divovf", 4'h4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 3);
        do_op("divwovf", 4'hC, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 3);
        do_op("mulw", 4'h8, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 35);
        do_op("illegal", 4'h9, 64'd5, 64'd6, 64'd0, 3);
        do_op("divuw", 4'hD, 64'h1234_5678_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 35);
        do_op("remw", 4'hE, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 35);

        // Flush during CALC cycle 10: op is dropped and never reported
        in_valid = 1'b1; op = 4'h0; src1 = 64'd5; src2 = 64'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("pre_flush_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (80) begin @(posedge clk); #1; if (out_valid === 1'b1) seen++; end
        check("flush_no_valid", 64'(seen), 64'd0);

        // Flush together with in_valid in IDLE: nothing accepted
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_busy", 64'(busy), 64'd0);

        // Writeback backpressure: result held stable in DONE
        in_valid = 1'b1; op = 4'h5; src1 = 64'd100; src2 = 64'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 0;
        while (out_valid !== 1'b1 && edges < 200) begin @(posedge clk); #1; edges++; end
        check("hold_lat", 64'(edges + 1), 64'd67);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", result, 64'd14);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold_release", {62'd0, out_valid, in_ready}, 64'd1);

        // Asynchronous reset in the middle of CALC
        in_valid = 1'b1; op = 4'h0; src1 = 64'd3; src2 = 64'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (80) begin @(posedge clk); #1; if (out_valid === 1'b1) seen++; end
        check("arst_no_valid", 64'(seen), 64'd0);

        do_op("post_rst_divu", 4'h5, 64'd100, 64'd7, 64'd14, 67);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
